// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Holds the PC, issues one request at
//               a time to instruction memory, and buffers a single returned
//               instruction (with its PC and opcode) for decode. A redirect
//               from execute replaces the PC and squashes any in-flight fetch.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous reset, active-high
//   imem_req     fetch request valid
//   imem_addr    word-aligned fetch address
//   imem_ready   memory accepts the request this cycle
//   imem_rvalid  read data valid (in order, >= 1 cycle after acceptance)
//   imem_rdata   instruction word from memory
//   redirect     taken branch/jump pulse
//   redirect_pc  target PC of the redirect (low two bits ignored)
//   stall        decode cannot consume this cycle
//   inst_valid   inst / inst_pc / opcode valid for decode
//   inst         buffered instruction word
//   inst_pc      address of the buffered instruction
//   opcode       inst[6:0]
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode
);

    localparam logic [1:0] c_st_req  = 2'd0;  // request presented
    localparam logic [1:0] c_st_wait = 2'd1;  // request accepted, response pending
    localparam logic [1:0] c_st_full = 2'd2;  // output buffer occupied

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;        // always word aligned
    logic [XLEN-1:0] r_req_pc;    // address of the outstanding request
    logic            r_kill;      // outstanding response must be dropped
    logic            r_inst_valid;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_pc;

    logic [XLEN-1:0] w_redirect_pc;
    logic            w_unused;

    // The low two bits of a redirect target carry no information.
    assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused      = ^redirect_pc[1:0];

    // r_pc is kept aligned at every write, so it can drive the address directly.
    assign imem_addr  = r_pc;
    // Gating with redirect guarantees no request is accepted in a redirect cycle.
    assign imem_req   = (r_state == c_st_req) & ~redirect & ~rst;

    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign opcode     = r_inst[6:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_req;
            r_pc         <= {RESET_PC[XLEN-1:2], 2'b00};
            r_req_pc     <= '0;
            r_kill       <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
        end else if (redirect) begin
            r_pc         <= w_redirect_pc;
            r_inst_valid <= 1'b0;
            if (r_state == c_st_wait && !imem_rvalid) begin
                // Response still owed by memory: remember to discard it.
                r_kill  <= 1'b1;
                r_state <= c_st_wait;
            end else begin
                // Either nothing outstanding, or the response arrives now and
                // is simply not captured.
                r_kill  <= 1'b0;
                r_state <= c_st_req;
            end
        end else begin
            case (r_state)
                c_st_req: begin
                    if (imem_ready) begin
                        r_req_pc <= r_pc;
                        r_state  <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (imem_rvalid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= c_st_req;
                        end else begin
                            r_inst       <= imem_rdata;
                            r_inst_pc    <= r_req_pc;
                            r_inst_valid <= 1'b1;
                            r_pc         <= r_req_pc + XLEN'(4);
                            r_state      <= c_st_full;
                        end
                    end
                end
                c_st_full: begin
                    if (r_inst_valid && !stall) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= c_st_req;
                    end
                end
                default: begin
                    r_state <= c_st_req;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed, table-driven bench for fetch_unit. Each vector
//               holds the inputs for one cycle and the outputs expected
//               during that cycle (before the clock edge that consumes it).
//               A second instance with RESET_PC = 0xFFFFFFFC covers PC wrap
//               and reset in the middle of a fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;

    logic        a_req,   b_req;
    logic [31:0] a_addr,  b_addr;
    logic        a_valid, b_valid;
    logic [31:0] a_inst,  b_inst;
    logic [31:0] a_pc,    b_pc;
    logic [6:0]  a_op,    b_op;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(a_req), .imem_addr(a_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .inst_valid(a_valid), .inst(a_inst), .inst_pc(a_pc), .opcode(a_op)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst),
        .imem_req(b_req), .imem_addr(b_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .inst_valid(b_valid), .inst(b_inst), .inst_pc(b_pc), .opcode(b_op)
    );

    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] rdata;
        logic        stl, rd;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst, e_pc;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Memory contents as a function of address; opcode field varies with it.
    function automatic logic [31:0] mw(input logic [31:0] a);
        return {a[24:0], a[8:2] ^ 7'h13};
    endfunction

    function automatic vec_t mk(input logic rst_i, rdy, rv, input logic [31:0] rdata,
                                input logic stl, rd, input logic [31:0] rpc,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_inst, e_pc);
        vec_t v;
        v.rst = rst_i; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
        v.stl = stl; v.rd = rd; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_inst = e_inst; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic cmp(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    // Drive one vector, check outputs mid-cycle, then let the edge happen.
    task automatic step(input vec_t v, input int idx, input bit use_w);
        rst = v.rst; imem_ready = v.rdy; imem_rvalid = v.rv; imem_rdata = v.rdata;
        stall = v.stl; redirect = v.rd; redirect_pc = v.rpc;
        @(negedge clk);
        if (use_w) begin
            cmp("imem_req",   idx, {31'b0, b_req},   {31'b0, v.e_req});
            cmp("imem_addr",  idx, b_addr,           v.e_addr);
            cmp("inst_valid", idx, {31'b0, b_valid}, {31'b0, v.e_valid});
            cmp("inst",       idx, b_inst,           v.e_inst);
            cmp("inst_pc",    idx, b_pc,             v.e_pc);
            cmp("opcode",     idx, {25'b0, b_op},    {25'b0, v.e_inst[6:0]});
        end else begin
            cmp("imem_req",   idx, {31'b0, a_req},   {31'b0, v.e_req});
            cmp("imem_addr",  idx, a_addr,           v.e_addr);
            cmp("inst_valid", idx, {31'b0, a_valid}, {31'b0, v.e_valid});
            cmp("inst",       idx, a_inst,           v.e_inst);
            cmp("inst_pc",    idx, a_pc,             v.e_pc);
            cmp("opcode",     idx, {25'b0, a_op},    {25'b0, v.e_inst[6:0]});
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    vec_t wtb[$];

    initial begin
        //             rst rdy rv rdata        stl rd rpc            req addr          vld inst          inst_pc
        // reset, then straight-line fetch of 0x0, 0x4, 0x8
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 1, mw(32'h0),    0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h4,         1, 32'h13,        32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h4,         0, 32'h13,        32'h0));
        tbl.push_back(mk(0, 0, 1, mw(32'h4),    0, 0, 32'h0,         0, 32'h4,         0, 32'h13,        32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h8,         1, mw(32'h4),     32'h4));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h8,         0, mw(32'h4),     32'h4));
        tbl.push_back(mk(0, 0, 1, mw(32'h8),    0, 0, 32'h0,         0, 32'h8,         0, mw(32'h4),     32'h4));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'hC,         1, mw(32'h8),     32'h8));
        // memory backpressure: three cycles not ready, then one accept only
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0, 0, 32'h0,    0, 0, 32'h0,         1, 32'hC,         0, mw(32'h8),     32'h8));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'hC,         0, mw(32'h8),     32'h8));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         0, 32'hC,         0, mw(32'h8),     32'h8));
        tbl.push_back(mk(0, 0, 1, mw(32'hC),    0, 0, 32'h0,         0, 32'hC,         0, mw(32'h8),     32'h8));
        // decode stall for four cycles, next request the cycle after release
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1, 0, 32'h0,    1, 0, 32'h0,         0, 32'h10,        1, mw(32'hC),     32'hC));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h10,        1, mw(32'hC),     32'hC));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h10,        0, mw(32'hC),     32'hC));
        // redirect to 0x103 while the fetch of 0x10 is in flight
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 32'h103,       0, 32'h10,        0, mw(32'hC),     32'hC));
        tbl.push_back(mk(0, 0, 1, mw(32'h10),   0, 0, 32'h0,         0, 32'h100,       0, mw(32'hC),     32'hC));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h100,       0, mw(32'hC),     32'hC));
        tbl.push_back(mk(0, 0, 1, mw(32'h100),  0, 0, 32'h0,         0, 32'h100,       0, mw(32'hC),     32'hC));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h104,       1, mw(32'h100),   32'h100));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h104,       0, mw(32'h100),   32'h100));
        tbl.push_back(mk(0, 0, 1, mw(32'h104),  0, 0, 32'h0,         0, 32'h104,       0, mw(32'h100),   32'h100));
        // redirect while the buffer is full and stalled
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h108,       1, mw(32'h104),   32'h104));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h40,        0, 32'h108,       1, mw(32'h104),   32'h104));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h40,        0, mw(32'h104),   32'h104));
        // redirect in REQ with memory ready: no request may be accepted
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 32'h80,        0, 32'h40,        0, mw(32'h104),   32'h104));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h80,        0, mw(32'h104),   32'h104));
        // redirect in the same cycle as rvalid: data dropped, no kill left over
        tbl.push_back(mk(0, 0, 1, mw(32'h80),   0, 1, 32'h200,       0, 32'h80,        0, mw(32'h104),   32'h104));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h200,       0, mw(32'h104),   32'h104));
        tbl.push_back(mk(0, 0, 1, mw(32'h200),  0, 0, 32'h0,         0, 32'h200,       0, mw(32'h104),   32'h104));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h204,       1, mw(32'h200),   32'h200));
        // stray rvalid outside WAIT is ignored
        tbl.push_back(mk(0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0,         1, 32'h204,       0, mw(32'h200),   32'h200));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h204,       0, mw(32'h200),   32'h200));

        // RESET_PC = 0xFFFFFFFC: wrap to 0, then reset while waiting on memory
        wtb.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'hFFFFFFFC,  0, 32'h0,         32'h0));
        wtb.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'hFFFFFFFC,  0, 32'h0,         32'h0));
        wtb.push_back(mk(0, 0, 1, mw(32'hFFFFFFFC), 0, 0, 32'h0,     0, 32'hFFFFFFFC,  0, 32'h0,         32'h0));
        wtb.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,         1, mw(32'hFFFFFFFC), 32'hFFFFFFFC));
        wtb.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,         0, mw(32'hFFFFFFFC), 32'hFFFFFFFC));
        wtb.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,         0, mw(32'hFFFFFFFC), 32'hFFFFFFFC));
        wtb.push_back(mk(1, 1, 0, 32'h0,        0, 0, 32'h0,         0, 32'hFFFFFFFC,  0, 32'h0,         32'h0));
        wtb.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'hFFFFFFFC,  0, 32'h0,         32'h0));

        rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) step(tbl[i], i, 1'b0);

        // Hand sequence: reset both instances before the wrap scenario.
        rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; stall = 1'b0; redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        foreach (wtb[i]) step(wtb[i], 100 + i, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
